// File: rtl/surf_regs_pkg.sv
// Shared word map and byte-lane helper for the SURF ident/control register slave.
package surf_regs_pkg;

  localparam int unsigned REG_IDENT     = 0;
  localparam int unsigned REG_DATEVER   = 1;
  localparam int unsigned REG_SCRATCH   = 2;
  localparam int unsigned REG_STATUS    = 3;
  localparam int unsigned REG_PULSE     = 4;
  localparam int unsigned REG_UPTIME    = 5;
  localparam int unsigned REG_CTRL_BASE = 8;

  // Replace each byte of old_w with the matching byte of new_w where sel is set.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = old_w;
    for (int unsigned b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/surf_wb_ack_gen.sv
// Detects a new WISHBONE request and issues exactly one single-cycle ack or err for it.
module surf_wb_ack_gen (
  input  logic clk,
  input  logic rst_n,
  input  logic cyc,
  input  logic stb,
  input  logic err_sel,
  output logic req,
  output logic ack,
  output logic err
);

  // Blocking on our own ack/err forces a one-cycle gap between responses.
  assign req = cyc & stb & ~ack & ~err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack <= 1'b0;
      err <= 1'b0;
    end else begin
      ack <= req & ~err_sel;
      err <= req & err_sel;
    end
  end

endmodule

// File: rtl/surf_id_ctrl_regs.sv
// WISHBONE register slave: ident, date/version, scratch, status, pulse strobes, uptime, control words.
// Optional macro WB_ERR_EN: unmapped words answer with wb_err_o instead of wb_ack_o.
module surf_id_ctrl_regs #(
  parameter logic [31:0]            IDENT         = "SURF",
  parameter logic [31:0]            DATEVERSION   = 32'h0,
  parameter int unsigned            ADDR_BITS     = 22,
  parameter int unsigned            REG_ADDR_BITS = 4,
  parameter int unsigned            NUM_CTRL      = 4,
  parameter logic [32*NUM_CTRL-1:0] CTRL_RESET    = '0
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_n_i,
  input  logic                     wb_cyc_i,
  input  logic                     wb_stb_i,
  input  logic                     wb_we_i,
  input  logic [ADDR_BITS-1:0]     wb_adr_i,
  input  logic [31:0]              wb_dat_i,
  input  logic [3:0]               wb_sel_i,
  output logic [31:0]              wb_dat_o,
  output logic                     wb_ack_o,
  output logic                     wb_err_o,
  input  logic [31:0]              status_i,
  output logic [32*NUM_CTRL-1:0]   ctrl_o,
  output logic [31:0]              pulse_o
);

  import surf_regs_pkg::*;

  logic [31:0] word_idx;
  logic        mapped;
  logic        err_sel;
  logic        req;
  logic [31:0] rd_data;
  logic [31:0] sel_mask;
  logic [31:0] scratch;
  logic [31:0] uptime;
  logic [31:0] ctrl_r [NUM_CTRL];
  logic        unused_adr;

  assign word_idx   = 32'(wb_adr_i[REG_ADDR_BITS+1:2]);
  assign mapped     = word_idx < (REG_CTRL_BASE + NUM_CTRL);
  assign sel_mask   = byte_merge('0, '1, wb_sel_i);
  assign unused_adr = ^wb_adr_i;

`ifdef WB_ERR_EN
  assign err_sel = ~mapped;
`else
  assign err_sel = 1'b0;
`endif

  surf_wb_ack_gen u_ack_gen (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_n_i),
    .cyc     (wb_cyc_i),
    .stb     (wb_stb_i),
    .err_sel (err_sel),
    .req     (req),
    .ack     (wb_ack_o),
    .err     (wb_err_o)
  );

  always_comb begin
    rd_data = '0;
    case (word_idx)
      REG_IDENT:   rd_data = IDENT;
      REG_DATEVER: rd_data = DATEVERSION;
      REG_SCRATCH: rd_data = scratch;
      REG_STATUS:  rd_data = status_i;
      REG_UPTIME:  rd_data = uptime;
      default:     rd_data = '0;
    endcase
    for (int unsigned i = 0; i < NUM_CTRL; i++) begin
      if (word_idx == REG_CTRL_BASE + i) rd_data = ctrl_r[i];
    end
  end

  always_comb begin
    ctrl_o = '0;
    for (int unsigned i = 0; i < NUM_CTRL; i++) begin
      ctrl_o[32*i +: 32] = ctrl_r[i];
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      uptime <= '0;
    end else begin
      uptime <= uptime + 32'd1;
    end
  end

  // Everything below commits on the request edge, i.e. the same edge that raises ack.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wb_dat_o <= '0;
      scratch  <= '0;
      pulse_o  <= '0;
    end else begin
      pulse_o <= '0;
      if (req) begin
        if (wb_we_i) begin
          if (word_idx == REG_SCRATCH) scratch <= byte_merge(scratch, wb_dat_i, wb_sel_i);
          if (word_idx == REG_PULSE)   pulse_o <= wb_dat_i & sel_mask;
        end else if (!err_sel) begin
          wb_dat_o <= rd_data;
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      for (int unsigned i = 0; i < NUM_CTRL; i++) begin
        ctrl_r[i] <= CTRL_RESET[32*i +: 32];
      end
    end else if (req && wb_we_i) begin
      for (int unsigned i = 0; i < NUM_CTRL; i++) begin
        if (word_idx == REG_CTRL_BASE + i) ctrl_r[i] <= byte_merge(ctrl_r[i], wb_dat_i, wb_sel_i);
      end
    end
  end

endmodule

// File: tb/tb_surf_id_ctrl_regs.sv
// Directed self-checking bench for surf_id_ctrl_regs; honours WB_ERR_EN when defined.
module tb_surf_id_ctrl_regs;

  localparam int unsigned AW = 22;
  localparam int unsigned NC = 4;
  localparam logic [32*NC-1:0] CRST = 128'h00000004_00000003_00000002_00000001;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cyc, stb, we;
  logic [AW-1:0]   adr;
  logic [31:0]     wdat;
  logic [3:0]      sel;
  logic [31:0]     dat_o;
  logic            ack, err;
  logic [31:0]     status;
  logic [32*NC-1:0] ctrl;
  logic [31:0]     pulse;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] rd, pa;
  logic        ga, ge;
  int          lat;

  always #5 clk = ~clk;

  surf_id_ctrl_regs #(
    .DATEVERSION (32'h1A2B0001),
    .ADDR_BITS   (AW),
    .NUM_CTRL    (NC),
    .CTRL_RESET  (CRST)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .wb_cyc_i   (cyc),
    .wb_stb_i   (stb),
    .wb_we_i    (we),
    .wb_adr_i   (adr),
    .wb_dat_i   (wdat),
    .wb_sel_i   (sel),
    .wb_dat_o   (dat_o),
    .wb_ack_o   (ack),
    .wb_err_o   (err),
    .status_i   (status),
    .ctrl_o     (ctrl),
    .pulse_o    (pulse)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One bus transfer starting at a falling edge; lat=0 means no response within the budget.
  task automatic xfer(input logic w, input int unsigned word, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] r, output logic a,
                      output logic e, output logic [31:0] p, output int l);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = AW'(word * 4); wdat = d; sel = s;
    l = 0; a = 1'b0; e = 1'b0; r = dat_o; p = '0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (ack || err) begin
        l = i; a = ack; e = err; r = dat_o; p = pulse;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; wdat = '0; sel = '0;
    status = 32'hCAFE0123;
    repeat (3) @(negedge clk);
    chk("rst_ctrl_during", ctrl, CRST);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ack", 128'(ack), 128'(1'b0));
    chk("rst_err", 128'(err), 128'(1'b0));
    chk("rst_dat", 128'(dat_o), 128'(32'h0));
    chk("rst_pulse", 128'(pulse), 128'(32'h0));
    chk("rst_ctrl", ctrl, CRST);

    xfer(1'b0, 0, '0, 4'hF, rd, ga, ge, pa, lat);
    chk("id_lat", 128'(lat), 128'(1));
    chk("id_ack", 128'(ga), 128'(1'b1));
    chk("id_dat", 128'(rd), 128'(32'h53555246));
    @(negedge clk);
    chk("id_ack_one_cycle", 128'(ack), 128'(1'b0));
    xfer(1'b0, 1, '0, 4'hF, rd, ga, ge, pa, lat);
    chk("dv_dat", 128'(rd), 128'(32'h1A2B0001));

    xfer(1'b1, 2, 32'hDEADBEEF, 4'b0101, rd, ga, ge, pa, lat);
    chk("scr_wr_ack", 128'(ga), 128'(1'b1));
    chk("scr_wr_dat_hold", 128'(rd), 128'(32'h1A2B0001));
    xfer(1'b0, 2, '0, 4'hF, rd, ga, ge, pa, lat);
    chk("scr_rd", 128'(rd), 128'(32'h00AD00EF));
    xfer(1'b1, 2, 32'hFFFFFFFF, 4'b0000, rd, ga, ge, pa, lat);
    chk("scr_sel0_ack", 128'(ga), 128'(1'b1));
    xfer(1'b0, 2, '0, 4'hF, rd, ga, ge, pa, lat);
    chk("scr_sel0_rd", 128'(rd), 128'(32'h00AD00EF));

    xfer(1'b0, 3, '0, 4'hF, rd, ga, ge, pa, lat);
    chk("status_rd", 128'(rd), 128'(32'hCAFE0123));

    chk("pulse_idle", 128'(pulse), 128'(32'h0));
    xfer(1'b1, 4, 32'h00000005, 4'hF, rd, ga, ge, pa, lat);
    chk("pulse_at_ack", 128'(pa), 128'(32'h5));
    @(negedge clk);
    chk("pulse_after", 128'(pulse), 128'(32'h0));
    xfer(1'b1, 4, 32'h0000FF01, 4'b0001, rd, ga, ge, pa, lat);
    chk("pulse_sel", 128'(pa), 128'(32'h1));
    xfer(1'b0, 4, '0, 4'hF, rd, ga, ge, pa, lat);
    chk("pulse_rd", 128'(rd), 128'(32'h0));

    xfer(1'b1, 6, 32'hFFFFFFFF, 4'hF, rd, ga, ge, pa, lat);
    xfer(1'b0, 6, '0, 4'hF, rd, ga, ge, pa, lat);
    chk("rsvd_rd", 128'(rd), 128'(32'h0));

    xfer(1'b1, 9, 32'hAABBCCDD, 4'b1100, rd, ga, ge, pa, lat);
    chk("ctrl_o_wr", ctrl, 128'h00000004_00000003_AABB0002_00000001);
    xfer(1'b0, 9, '0, 4'hF, rd, ga, ge, pa, lat);
    chk("ctrl_rd", 128'(rd), 128'(32'hAABB0002));
    xfer(1'b1, 11, 32'h11223344, 4'hF, rd, ga, ge, pa, lat);
    chk("ctrl_last_wr", ctrl, 128'h11223344_00000003_AABB0002_00000001);

    xfer(1'b1, 0, 32'h0, 4'hF, rd, ga, ge, pa, lat);
    chk("ro_wr_ack", 128'(ga), 128'(1'b1));
    xfer(1'b0, 0, '0, 4'hF, rd, ga, ge, pa, lat);
    chk("ro_unchanged", 128'(rd), 128'(32'h53555246));

    xfer(1'b0, 15, '0, 4'hF, rd, ga, ge, pa, lat);
    chk("unm_lat", 128'(lat), 128'(1));
`ifdef WB_ERR_EN
    chk("unm_err", 128'(ge), 128'(1'b1));
    chk("unm_ack", 128'(ga), 128'(1'b0));
    chk("unm_dat_hold", 128'(rd), 128'(32'h53555246));
`else
    chk("unm_err", 128'(ge), 128'(1'b0));
    chk("unm_ack", 128'(ga), 128'(1'b1));
    chk("unm_dat", 128'(rd), 128'(32'h0));
`endif

    // Held strobe on uptime, starting just below the wrap point.
    @(negedge clk);
    force dut.uptime = 32'hFFFFFFFE;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = AW'(5 * 4); sel = 4'hF;
    #1 release dut.uptime;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("hold_ack_c%0d", k), 128'(ack), 128'((k % 2) == 1));
      if (k == 1) chk("up_c1", 128'(dat_o), 128'(32'hFFFFFFFE));
      if (k == 3) chk("up_c3_wrap", 128'(dat_o), 128'(32'h00000000));
      if (k == 5) chk("up_c5", 128'(dat_o), 128'(32'h00000002));
    end
    cyc = 1'b0; stb = 1'b0;

    // Reset lands between request and ack of a ctrl write.
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = AW'(8 * 4); wdat = 32'h12345678; sel = 4'hF;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ack", 128'(ack), 128'(1'b0));
    chk("mid_rst_ctrl", ctrl, CRST);
    @(posedge clk); #1;
    chk("mid_rst_ack_edge", 128'(ack), 128'(1'b0));
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ack", 128'(ack), 128'(1'b0));
    chk("post_rst_ctrl", ctrl, CRST);
    xfer(1'b0, 2, '0, 4'hF, rd, ga, ge, pa, lat);
    chk("post_rst_scr", 128'(rd), 128'(32'h0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/surf_id_ctrl_regs.md
Name: surf_id_ctrl_regs

Overview:
Parametrised WISHBONE register slave that replaces the fixed two-word ident/version responder behind the serial-bus master. Provides identification, firmware date/version, a scratch word, a status word, write-1-to-pulse strobes, a free-running uptime counter and NUM_CTRL byte-writable control words. Sits on the regclk domain between the UART bus master and SURF control logic.

Parameters:
IDENT, "SURF", 32-bit ASCII identification word returned at word 0.
DATEVERSION, 32'h0, {date[15:0], major[3:0], minor[3:0], rev[7:0]} returned at word 1.
ADDR_BITS, 22, width of wb_adr_i.
REG_ADDR_BITS, 4, word-address bits decoded (adr[REG_ADDR_BITS+1:2]); 16 words.
NUM_CTRL, 4, number of control words at word 8 upward; legal range 1..8.
CTRL_RESET, {NUM_CTRL{32'h0}}, reset value of ctrl_o, packed with word 0 in the LSBs.

Ports:
wb_clk_i  in  1  register clock; all logic on rising edge.
wb_rst_n_i  in  1  asynchronous, active-low reset.
wb_cyc_i  in  1  bus cycle.
wb_stb_i  in  1  strobe.
wb_we_i  in  1  write enable.
wb_adr_i  in  ADDR_BITS  byte address; bits [1:0] ignored.
wb_dat_i  in  32  write data.
wb_sel_i  in  4  byte selects.
wb_dat_o  out  32  read data, registered.
wb_ack_o  out  1  transfer acknowledge.
wb_err_o  out  1  error acknowledge (WB_ERR_EN only; else tied 0).
status_i  in  32  status bits, same clock domain.
ctrl_o  out  32*NUM_CTRL  control words.
pulse_o  out  32  one-cycle strobes.

Behaviour:
- Reset (async assert, sync release): wb_ack_o=0, wb_err_o=0, wb_dat_o=0, scratch=0, ctrl_o=CTRL_RESET, pulse_o=0, uptime=0.
- Request = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o. Exactly one ack/err per request, asserted on the edge after the request is seen and held one cycle. No back-to-back acks; a held strobe re-requests on the cycle after ack drops.
- Map (word index): 0 IDENT RO; 1 DATEVERSION RO; 2 scratch RW; 3 status_i RO, sampled at the request edge; 4 pulse W1P, reads 0; 5 uptime RO; 6-7 reserved, read 0; 8..8+NUM_CTRL-1 ctrl RW; remainder unmapped.
- Writes commit on the edge that asserts ack. Byte-wise per wb_sel_i for scratch and ctrl. sel=0 is acked with no change. Writes to RO or reserved words are acked and ignored.
- pulse_o[i]=1 for exactly one cycle, coincident with ack, for each bit written 1 to word 4 within the selected bytes. Otherwise 0.
- uptime: 32-bit, increments every cycle, wraps FFFFFFFF->0. A read returns the value at the request edge.
- Unmapped word: acked with data 0, writes ignored (without WB_ERR_EN).
- wb_dat_o updates only with ack and holds until the next ack. Write acks leave wb_dat_o unchanged.
- If wb_cyc_i drops while ack is high, nothing is cancelled; the write has already committed.
- Reset asserted mid-transaction: ack/err clear immediately; any uncommitted write is lost.

Optional Feature:
WB_ERR_EN: when defined, an unmapped word (index >= 8+NUM_CTRL) asserts wb_err_o instead of wb_ack_o (same timing) and wb_dat_o is unchanged. Writes to RO words still ack. When undefined, wb_err_o is constant 0 and unmapped accesses ack with read data 0.

Decomposition:
- Package surf_regs_pkg: word-index localparams (REG_IDENT=0, REG_DATEVER=1, REG_SCRATCH=2, REG_STATUS=3, REG_PULSE=4, REG_UPTIME=5, REG_CTRL_BASE=8).
- Package also holds function byte_merge(old, new, sel).
- One sub-module: surf_wb_ack_gen (request detect, single ack/err pulse generation).

Test Plan:
- Read word 0 then word 1 with DATEVERSION=32'h1A2B0001 -> ack one cycle after strobe; dat_o=32'h53555246 ("SURF"), then 32'h1A2B0001.
- Write scratch 32'hDEADBEEF sel=4'b0101, then read -> 32'h00AD00EF.
- Write word 4 data 32'h00000005 -> pulse_o=32'h5 for exactly the ack cycle, 0 otherwise; reading word 4 returns 0.
- Hold strobe 6 cycles reading uptime -> acks at cycles 1,3,5; successive values differ by 2. Force wrap near FFFFFFFF -> reads 0 after wrap.
- Assert reset during a ctrl write request, before ack -> no ack, ctrl_o = CTRL_RESET.
- Read word 15 with NUM_CTRL=4 -> without WB_ERR_EN, ack with data 0; with WB_ERR_EN, err=1 and ack=0.
